rat_intr_ctrl: RTL and testbench

Interrupt and flag-sequencing controller for the RAT CPU, sitting directly upstream of the C/Z flag registers, their shadow registers and the flag-load mux. Synchronises the external interrupt line, owns the interrupt-enable (I) flag, accepts interrupts only at instruction boundaries, and generates the flag-save (shadow load) and flag-restore (mux select plus load) strobes for interrupt entry and RETIE/RETID. Also signals the control unit to vector the PC.

---
 rtl/rat_pkg.sv | 19 +
 rtl/intr_sync.sv | 36 +++
 rtl/rat_intr_ctrl.sv | 124 ++++++++++++
 tb/tb_rat_intr_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/rat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rat_pkg                                                         |
// | Purpose  : Shared types and constants for the RAT interrupt controller.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package rat_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENTER   = 2'd1,
      ISR     = 2'd2,
      RESTORE = 2'd3
   } intr_state_t;

   localparam logic [9:0] INTR_VECTOR = 10'h3FF;

endpackage
`default_nettype wire

// File: rtl/intr_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : intr_sync                                                       |
// | Purpose  : INTR synchroniser chain plus registered rising-edge event pulse.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module intr_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic INTR,
   output logic EVT
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_evt;

   // Event is registered so it lands one edge after the synchronised level rises.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_evt  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], INTR};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_evt  <= r_sync[SYNC_STAGES-1] & ~r_prev;
      end
   end

   assign EVT = r_evt;

endmodule
`default_nettype wire

// File: rtl/rat_intr_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rat_intr_ctrl                                                   |
// | Purpose  : RAT interrupt entry/return sequencing and C/Z flag save/restore.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rat_intr_ctrl
   import rat_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             INTR,
   input  logic             EXEC_DONE,
   input  logic             SEI,
   input  logic             CLI,
   input  logic             RETIE,
   input  logic             RETID,
   output logic             I_FLAG,
   output logic             INTR_TAKE,
   output logic             FLG_SHAD_LD,
   output logic             FLG_LD_SEL,
   output logic             FLG_C_LD,
   output logic             FLG_Z_LD,
   output logic             IN_ISR,
   output logic [CNT_W-1:0] INTR_CNT
);

   intr_state_t      r_state;
   intr_state_t      w_state_nxt;
   logic             w_evt;
   logic             w_ret;
   logic             w_take_ok;
   logic             r_pend;
   logic             r_i_flag;
   logic             w_i_flag_nxt;
   logic             r_ret_ie;
   logic [CNT_W-1:0] r_cnt;

   intr_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_intr_sync (
      .CLK  (CLK),
      .RST_N(RST_N),
      .INTR (INTR),
      .EVT  (w_evt)
   );

   assign w_ret     = EXEC_DONE & (RETIE | RETID);
   assign w_take_ok = EXEC_DONE & r_pend & r_i_flag & ~RETIE & ~RETID;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Outputs decode from the state register only, so reset kills them at once.
   always_comb begin
      w_state_nxt = r_state;
      INTR_TAKE   = 1'b0;
      FLG_SHAD_LD = 1'b0;
      FLG_LD_SEL  = 1'b0;
      FLG_C_LD    = 1'b0;
      FLG_Z_LD    = 1'b0;
      IN_ISR      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_ret)          w_state_nxt = RESTORE;
            else if (w_take_ok) w_state_nxt = ENTER;
         end
         ENTER: begin
            INTR_TAKE   = 1'b1;
            FLG_SHAD_LD = 1'b1;
            w_state_nxt = ISR;
         end
         ISR: begin
            IN_ISR = 1'b1;
            if (w_ret) w_state_nxt = RESTORE;
         end
         RESTORE: begin
            FLG_LD_SEL  = 1'b1;
            FLG_C_LD    = 1'b1;
            FLG_Z_LD    = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_i_flag_nxt = r_i_flag;
      if (r_state == ENTER)
         w_i_flag_nxt = 1'b0;
      else if (r_state == RESTORE)
         w_i_flag_nxt = r_ret_ie;
      else if (EXEC_DONE) begin
         if (CLI)      w_i_flag_nxt = 1'b0;
         else if (SEI) w_i_flag_nxt = 1'b1;
      end
   end

   // A new edge during ENTER must survive ENTER's clear of the pending latch.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_pend   <= 1'b0;
         r_i_flag <= 1'b0;
         r_ret_ie <= 1'b0;
         r_cnt    <= '0;
      end else begin
         if (w_evt)                 r_pend <= 1'b1;
         else if (r_state == ENTER) r_pend <= 1'b0;
         r_i_flag <= w_i_flag_nxt;
         if (w_ret) r_ret_ie <= RETIE;
         if ((r_state == ENTER) && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
      end
   end

   assign I_FLAG   = r_i_flag;
   assign INTR_CNT = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rat_intr_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_rat_intr_ctrl                                                |
// | Purpose  : Self-checking bench for rat_intr_ctrl (CNT_W=8 and CNT_W=2).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_rat_intr_ctrl;

   // Output bits: {I_FLAG, INTR_TAKE, FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD, IN_ISR}
   localparam logic [6:0] O_NONE = 7'b0000000;
   localparam logic [6:0] O_I    = 7'b1000000;
   localparam logic [6:0] O_ENT  = 7'b0110000;
   localparam logic [6:0] O_RST  = 7'b0001110;
   localparam logic [6:0] O_ISR  = 7'b0000001;

   logic CLK = 1'b0;
   logic RST_N, INTR, EXEC_DONE, SEI, CLI, RETIE, RETID;

   logic       I_FLAG, INTR_TAKE, FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD, IN_ISR;
   logic [7:0] INTR_CNT;
   logic       I_FLAG2, INTR_TAKE2, FLG_SHAD_LD2, FLG_LD_SEL2, FLG_C_LD2, FLG_Z_LD2, IN_ISR2;
   logic [1:0] INTR_CNT2;

   typedef struct {
      logic       intr, ed, sei, cli, rie, rid;
      logic [6:0] o;
      int         cnt;
   } vec_t;

   typedef struct {
      logic [6:0] o;
      int         cnt;
   } exp_t;

   vec_t vt[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 CLK = ~CLK;

   rat_intr_ctrl #(.SYNC_STAGES(2), .CNT_W(8)) dut (
      .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .EXEC_DONE(EXEC_DONE), .SEI(SEI), .CLI(CLI),
      .RETIE(RETIE), .RETID(RETID), .I_FLAG(I_FLAG), .INTR_TAKE(INTR_TAKE),
      .FLG_SHAD_LD(FLG_SHAD_LD), .FLG_LD_SEL(FLG_LD_SEL), .FLG_C_LD(FLG_C_LD),
      .FLG_Z_LD(FLG_Z_LD), .IN_ISR(IN_ISR), .INTR_CNT(INTR_CNT)
   );

   rat_intr_ctrl #(.SYNC_STAGES(2), .CNT_W(2)) dut2 (
      .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .EXEC_DONE(EXEC_DONE), .SEI(SEI), .CLI(CLI),
      .RETIE(RETIE), .RETID(RETID), .I_FLAG(I_FLAG2), .INTR_TAKE(INTR_TAKE2),
      .FLG_SHAD_LD(FLG_SHAD_LD2), .FLG_LD_SEL(FLG_LD_SEL2), .FLG_C_LD(FLG_C_LD2),
      .FLG_Z_LD(FLG_Z_LD2), .IN_ISR(IN_ISR2), .INTR_CNT(INTR_CNT2)
   );

   wire logic [6:0] w_o = {I_FLAG, INTR_TAKE, FLG_SHAD_LD, FLG_LD_SEL, FLG_C_LD, FLG_Z_LD, IN_ISR};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic intr, input logic ed, input logic sei, input logic cli,
                               input logic rie, input logic rid, input logic [6:0] o, input int cnt);
      vec_t v;
      v.intr = intr; v.ed = ed; v.sei = sei; v.cli = cli; v.rie = rie; v.rid = rid;
      v.o = o; v.cnt = cnt;
      vt.push_back(v);
   endfunction

   task automatic drive(input logic intr, input logic ed, input logic sei, input logic cli,
                        input logic rie, input logic rid);
      INTR = intr; EXEC_DONE = ed; SEI = sei; CLI = cli; RETIE = rie; RETID = rid;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int takes;
      exp_t e;
      int   e2;

      // intr, ed, sei, cli, retie, retid, expected outputs, expected count
      add(0,0,0,0,0,0, O_NONE, 0);
      add(0,1,1,0,0,0, O_I, 0);
      add(1,0,0,0,0,0, O_I, 0);
      add(1,0,0,0,0,0, O_I, 0);
      add(1,0,0,0,0,0, O_I, 0);
      add(1,0,0,0,0,0, O_I, 0);
      add(1,1,0,0,0,0, O_I | O_ENT, 0);
      add(1,0,0,0,0,0, O_ISR, 1);
      add(0,0,0,0,0,0, O_ISR, 1);
      add(0,1,0,0,1,0, O_RST, 1);
      add(0,0,0,0,0,0, O_I, 1);
      for (int i = 0; i < 4; i++) add(1,0,0,0,0,0, O_I, 1);
      add(0,1,0,0,0,0, O_I | O_ENT, 1);
      add(0,0,0,0,0,0, O_ISR, 2);
      add(0,1,0,0,0,1, O_RST, 2);
      add(0,0,0,0,0,0, O_NONE, 2);
      add(0,1,1,1,0,0, O_NONE, 2);
      add(0,1,1,0,0,0, O_I, 2);
      // three edges merge into one pending request
      for (int i = 0; i < 3; i++) begin
         add(1,0,0,0,0,0, O_I, 2);
         add(0,0,0,0,0,0, O_I, 2);
      end
      add(0,0,0,0,0,0, O_I, 2);
      add(0,0,0,0,0,0, O_I, 2);
      add(0,1,0,0,0,0, O_I | O_ENT, 2);
      add(0,0,0,0,0,0, O_ISR, 3);
      add(0,1,0,0,1,0, O_RST, 3);
      add(0,0,0,0,0,0, O_I, 3);
      add(0,1,0,0,0,0, O_I, 3);
      add(0,0,0,0,0,0, O_I, 3);
      // second edge timed to be seen during ENTER
      add(1,0,0,0,0,0, O_I, 3);
      add(0,0,0,0,0,0, O_I, 3);
      add(1,0,0,0,0,0, O_I, 3);
      add(1,0,0,0,0,0, O_I, 3);
      add(1,1,0,0,0,0, O_I | O_ENT, 3);
      add(1,0,0,0,0,0, O_ISR, 4);
      add(0,1,0,0,1,0, O_RST, 4);
      add(0,0,0,0,0,0, O_I, 4);
      add(0,1,0,0,0,0, O_I | O_ENT, 4);
      add(0,0,0,0,0,0, O_ISR, 5);
      add(0,1,1,0,0,0, O_ISR | O_I, 5);
      add(0,1,0,0,0,0, O_ISR | O_I, 5);
      add(0,1,0,0,0,1, O_RST | O_I, 5);
      add(0,0,0,0,0,0, O_NONE, 5);
      // SEI at the same boundary as a pending request
      add(1,0,0,0,0,0, O_NONE, 5);
      add(1,0,0,0,0,0, O_NONE, 5);
      add(1,0,0,0,0,0, O_NONE, 5);
      add(0,0,0,0,0,0, O_NONE, 5);
      add(0,1,1,0,0,0, O_I, 5);
      add(0,0,0,0,0,0, O_I, 5);
      add(0,1,0,0,0,0, O_I | O_ENT, 5);
      add(0,0,0,0,0,0, O_ISR, 6);
      add(0,1,0,0,1,0, O_RST, 6);
      add(0,0,0,0,0,0, O_I, 6);
      add(0,1,0,0,0,1, O_RST | O_I, 6);
      add(0,0,0,0,0,0, O_NONE, 6);

      // Reset with INTR high
      RST_N = 1'b0;
      drive(1,0,0,0,0,0);
      repeat (3) tick();
      check("reset outputs", w_o, O_NONE);
      check("reset cnt", INTR_CNT, 0);
      check("reset cnt2", INTR_CNT2, 0);
      RST_N = 1'b1;
      takes = 0;
      for (int i = 0; i < 50; i++) begin
         EXEC_DONE = (i % 4 == 0);
         tick();
         if (INTR_TAKE) takes++;
      end
      EXEC_DONE = 1'b0;
      check("no take with I=0", takes, 0);
      check("I stays 0", I_FLAG, 0);
      check("pend after reset", dut.r_pend, 1);

      RST_N = 1'b0;
      drive(0,0,0,0,0,0);
      repeat (2) tick();
      RST_N = 1'b1;

      foreach (vt[i]) begin
         exp_t p;
         drive(vt[i].intr, vt[i].ed, vt[i].sei, vt[i].cli, vt[i].rie, vt[i].rid);
         p.o = vt[i].o;
         p.cnt = vt[i].cnt;
         sb.push_back(p);
         tick();
         e = sb.pop_front();
         e2 = (e.cnt > 3) ? 3 : e.cnt;
         check($sformatf("row%0d outputs", i), w_o, e.o);
         check($sformatf("row%0d cnt", i), INTR_CNT, e.cnt);
         check($sformatf("row%0d cnt2", i), INTR_CNT2, e2);
      end

      // Reset asserted mid-ENTER
      drive(0,1,1,0,0,0);
      tick();
      drive(1,0,0,0,0,0);
      repeat (4) tick();
      drive(1,1,0,0,0,0);
      tick();
      drive(1,0,0,0,0,0);
      check("enter take", INTR_TAKE, 1);
      check("enter shad", FLG_SHAD_LD, 1);
      #2 RST_N = 1'b0;
      #1;
      check("rst mid-enter take", INTR_TAKE, 0);
      check("rst mid-enter shad", FLG_SHAD_LD, 0);
      check("rst mid-enter cnt", INTR_CNT, 0);
      check("rst mid-enter cnt2", INTR_CNT2, 0);
      check("rst mid-enter I", I_FLAG, 0);
      drive(0,0,0,0,0,0);
      tick();
      RST_N = 1'b1;
      tick();
      check("post-reset idle", w_o, O_NONE);

      // Reset asserted mid-RESTORE (software RETIE from IDLE)
      drive(0,1,0,0,1,0);
      tick();
      drive(0,0,0,0,0,0);
      check("restore strobes", w_o, O_RST);
      #2 RST_N = 1'b0;
      #1;
      check("rst mid-restore", w_o, O_NONE);
      tick();
      RST_N = 1'b1;
      tick();
      check("post-restore-reset I", I_FLAG, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
